// File: rtl/fila_pkg.sv
// Shared types and constants for the fila queue arbiter.
package fila_pkg;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    PROD0 = 2'd0,
    PROD1 = 2'd1,
    CONS  = 2'd2
  } req_id_t;

  // Round-robin successor: prod0 -> prod1 -> cons -> prod0.
  function automatic req_id_t rr_next(input req_id_t id);
    case (id)
      PROD0:   return PROD1;
      PROD1:   return CONS;
      default: return PROD0;
    endcase
  endfunction

endpackage

// File: rtl/fila_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: first eligible requester at or after the pointer.
module rr_pick
  import fila_pkg::*;
(
  input  logic [2:0] elig_i,
  input  req_id_t    ptr_i,
  output logic       vld_o,
  output req_id_t    id_o
);

  req_id_t cand;

  // Walk the three positions starting at the pointer, keep the first eligible one.
  always_comb begin
    vld_o = 1'b0;
    id_o  = ptr_i;
    cand  = ptr_i;
    for (int k = 0; k < 3; k++) begin
      if (!vld_o && elig_i[cand]) begin
        vld_o = 1'b1;
        id_o  = cand;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/fila_arbiter.sv
// Sequencer/arbiter sharing the fila byte queue between two producers and one consumer.
// One operation per three cycles: IDLE (grant), ISSUE (pulse to fila), SETTLE (ack, len update).
module fila_arbiter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             prod0_req_in,
  input  logic [WIDTH-1:0] prod0_data_in,
  output logic             prod0_ack_out,
  input  logic             prod1_req_in,
  input  logic [WIDTH-1:0] prod1_data_in,
  output logic             prod1_ack_out,
  input  logic             cons_req_in,
  output logic             cons_ack_out,
  output logic [WIDTH-1:0] cons_data_out,
  input  logic [7:0]       len_in,
  input  logic [WIDTH-1:0] fifo_data_in,
  output logic             enqueue_out,
  output logic             dequeue_out,
  output logic [WIDTH-1:0] data_out,
  output logic             full_out,
  output logic             empty_out
);

  import fila_pkg::*;

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  arb_state_t       state_q, state_d;
  req_id_t          ptr_q, ptr_d;
  req_id_t          grant_q, grant_d;
  logic             enq_q, enq_d;
  logic             deq_q, deq_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             cack_q, cack_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] cdata_q, cdata_d;

  logic       room, avail;
  logic [2:0] elig;
  logic       pick_vld;
  req_id_t    pick_id;

  assign room      = (len_in < DEPTH_L);
  assign avail     = (len_in != 8'd0);
  assign full_out  = !room;
  assign empty_out = !avail;

  // Bit order matches req_id_t encoding.
  assign elig = {cons_req_in & avail, prod1_req_in & room, prod0_req_in & room};

  rr_pick u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .vld_o  (pick_vld),
    .id_o   (pick_id)
  );

  // Next-state and registered-output logic; pulses and acks default low every cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    enq_d   = 1'b0;
    deq_d   = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    cack_d  = 1'b0;
    dout_d  = dout_q;
    cdata_d = cdata_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ISSUE;
          grant_d = pick_id;
          ptr_d   = rr_next(pick_id);
          case (pick_id)
            PROD0: begin
              enq_d  = 1'b1;
              dout_d = prod0_data_in;
            end
            PROD1: begin
              enq_d  = 1'b1;
              dout_d = prod1_data_in;
            end
            default: deq_d = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        state_d = SETTLE;
        case (grant_q)
          PROD0: ack0_d = 1'b1;
          PROD1: ack1_d = 1'b1;
          default: begin
            // Head is still the pre-removal byte on this edge.
            cack_d  = 1'b1;
            cdata_d = fifo_data_in;
          end
        endcase
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight operation without a pulse or ack.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PROD0;
      grant_q <= PROD0;
      enq_q   <= 1'b0;
      deq_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      cack_q  <= 1'b0;
      dout_q  <= '0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      enq_q   <= enq_d;
      deq_q   <= deq_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      cack_q  <= cack_d;
      dout_q  <= dout_d;
      cdata_q <= cdata_d;
    end
  end

  assign enqueue_out   = enq_q;
  assign dequeue_out   = deq_q;
  assign data_out      = dout_q;
  assign prod0_ack_out = ack0_q;
  assign prod1_ack_out = ack1_q;
  assign cons_ack_out  = cack_q;
  assign cons_data_out = cdata_q;

endmodule

// File: tb/tb_fila_arbiter.sv
// Directed bench for fila_arbiter with a small behavioural fila queue attached.
`timescale 1ns/1ps
module tb_fila_arbiter;

  logic       clk, rst;
  logic       p0r, p1r, cr;
  logic [7:0] p0d, p1d;
  logic       p0a, p1a, ca;
  logic [7:0] cd, len, head, dout;
  logic       enq, deq, full, empty;

  int nchk = 0;
  int nerr = 0;

  // Behavioural fila: 8-entry circular queue, len and head visible after each edge.
  logic [7:0] fmem [8];
  logic [2:0] wp, rp, rp1;
  logic [7:0] fcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= 3'd0;
      rp   <= 3'd0;
      fcnt <= 8'd0;
    end else if (enq && fcnt < 8'd8) begin
      fmem[wp] <= dout;
      wp       <= wp + 3'd1;
      fcnt     <= fcnt + 8'd1;
    end else if (deq && fcnt != 8'd0) begin
      rp   <= rp + 3'd1;
      fcnt <= fcnt - 8'd1;
    end
  end

  assign len  = fcnt;
  assign head = fmem[rp];
  assign rp1  = rp + 3'd1;

  fila_arbiter #(.DEPTH(8), .WIDTH(8)) dut (
    .clk_10KHz     (clk),
    .reset         (rst),
    .prod0_req_in  (p0r),
    .prod0_data_in (p0d),
    .prod0_ack_out (p0a),
    .prod1_req_in  (p1r),
    .prod1_data_in (p1d),
    .prod1_ack_out (p1a),
    .cons_req_in   (cr),
    .cons_ack_out  (ca),
    .cons_data_out (cd),
    .len_in        (len),
    .fifo_data_in  (head),
    .enqueue_out   (enq),
    .dequeue_out   (deq),
    .data_out      (dout),
    .full_out      (full),
    .empty_out     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Lone prod0 request from IDLE: grant next edge, pulse, ack, back to IDLE.
  task automatic push0(input logic [7:0] d);
    p0r = 1'b1; p0d = d;
    tick();
    chk("push0_enq", enq, 1);
    chk("push0_data", dout, d);
    tick();
    chk("push0_ack", p0a, 1);
    p0r = 1'b0;
    tick();
  endtask

  logic [1:0] exp_kind [6];
  logic [7:0] exp_cd   [6];

  initial begin
    rst = 1'b1; p0r = 0; p1r = 0; cr = 0; p0d = 0; p1d = 0;
    @(negedge clk); @(negedge clk);
    // Reset state
    chk("rst_enq", enq, 0);
    chk("rst_deq", deq, 0);
    chk("rst_acks", {p0a, p1a, ca}, 0);
    chk("rst_dout", dout, 0);
    chk("rst_cd", cd, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    rst = 1'b0;

    // Single prod0 enqueue timing
    p0r = 1'b1; p0d = 8'h11;
    tick();
    chk("t1_enq", enq, 1);
    chk("t1_data", dout, 8'h11);
    chk("t1_ack_early", p0a, 0);
    tick();
    chk("t1_ack", p0a, 1);
    chk("t1_enq_drop", enq, 0);
    chk("t1_len", len, 1);
    p0r = 1'b0;
    tick();
    chk("t1_ack_one", p0a, 0);
    chk("t1_dout_hold", dout, 8'h11);

    // Two producers together: prod0 first, prod1 three cycles later
    do_reset();
    p0r = 1'b1; p0d = 8'h22; p1r = 1'b1; p1d = 8'h33;
    tick();
    chk("t2_g0_enq", enq, 1);
    chk("t2_g0_data", dout, 8'h22);
    tick();
    chk("t2_ack0", p0a, 1);
    chk("t2_ack1_not", p1a, 0);
    p0r = 1'b0;
    tick();
    chk("t2_gap", enq, 0);
    tick();
    chk("t2_g1_enq", enq, 1);
    chk("t2_g1_data", dout, 8'h33);
    tick();
    chk("t2_ack1", p1a, 1);
    chk("t2_len", len, 2);
    chk("t2_q0", head, 8'h22);
    chk("t2_q1", fmem[rp1], 8'h33);
    p1r = 1'b0;
    tick();

    // Fill to 8, prod1 stalls while full, consumer drains one, prod1 completes
    for (int i = 0; i < 6; i++) push0(8'hA0 + 8'(i));
    chk("t3_len8", len, 8);
    chk("t3_full", full, 1);
    p1r = 1'b1; p1d = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_no_enq_full", enq, 0);
    end
    cr = 1'b1;
    tick();
    chk("t3_deq", deq, 1);
    chk("t3_deq_only", enq, 0);
    tick();
    chk("t3_cack", ca, 1);
    chk("t3_cdata", cd, 8'h22);
    chk("t3_len7", len, 7);
    cr = 1'b0;
    tick();
    tick();
    chk("t3_p1_enq", enq, 1);
    chk("t3_p1_data", dout, 8'h55);
    tick();
    chk("t3_p1_ack", p1a, 1);
    chk("t3_len8b", len, 8);
    p1r = 1'b0;
    tick();

    // Empty queue: consumer waits until prod0 supplies 0x44
    do_reset();
    cr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_deq", deq, 0);
      chk("t4_empty", empty, 1);
    end
    p0r = 1'b1; p0d = 8'h44;
    tick();
    chk("t4_enq", enq, 1);
    chk("t4_no_deq2", deq, 0);
    chk("t4_cd_hold", cd, 0);
    tick();
    chk("t4_ack0", p0a, 1);
    p0r = 1'b0;
    tick();
    tick();
    chk("t4_deq", deq, 1);
    tick();
    chk("t4_cack", ca, 1);
    chk("t4_cdata", cd, 8'h44);
    chk("t4_len0", len, 0);
    cr = 1'b0;
    tick();

    // Half-full queue, all three requesting: strict rotation
    for (int i = 0; i < 5; i++) push0(8'h60 + 8'(i));
    cr = 1'b1;
    tick();
    chk("t5_pre_deq", deq, 1);
    tick();
    chk("t5_pre_cd", cd, 8'h60);
    cr = 1'b0;
    tick();
    chk("t5_len4", len, 4);
    exp_kind[0] = 2'd0; exp_kind[1] = 2'd1; exp_kind[2] = 2'd2;
    exp_kind[3] = 2'd0; exp_kind[4] = 2'd1; exp_kind[5] = 2'd2;
    exp_cd[2] = 8'h61; exp_cd[5] = 8'h62;
    exp_cd[0] = 8'h0;  exp_cd[1] = 8'h0; exp_cd[3] = 8'h0; exp_cd[4] = 8'h0;
    p0r = 1'b1; p0d = 8'h70; p1r = 1'b1; p1d = 8'h71; cr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_enq", enq, exp_kind[k] != 2'd2);
      chk("t5_deq", deq, exp_kind[k] == 2'd2);
      if (exp_kind[k] != 2'd2) chk("t5_data", dout, exp_kind[k] == 2'd0 ? 8'h70 : 8'h71);
      tick();
      chk("t5_acks", {ca, p1a, p0a}, 3'b001 << exp_kind[k]);
      if (exp_kind[k] == 2'd2) chk("t5_cdata", cd, exp_cd[k]);
      if (k == 5) begin
        p0r = 1'b0; p1r = 1'b0; cr = 1'b0;
      end
      tick();
    end
    chk("t5_len6", len, 6);

    // Reset during ISSUE aborts the enqueue; pointer returns to prod0
    p0r = 1'b1; p0d = 8'h99;
    tick();
    chk("t6_enq", enq, 1);
    rst = 1'b1;
    #1;
    chk("t6_enq_drop", enq, 0);
    chk("t6_dout_clr", dout, 0);
    chk("t6_ack_none", p0a, 0);
    @(posedge clk); @(negedge clk);
    chk("t6_rst_pulse", {enq, deq, p0a, p1a, ca}, 0);
    rst = 1'b0;
    p1r = 1'b1; p1d = 8'hAB;
    tick();
    chk("t6_regrant_p0", dout, 8'h99);
    chk("t6_regrant_enq", enq, 1);
    tick();
    chk("t6_ack0", {p1a, p0a}, 2'b01);
    chk("t6_len1", len, 1);
    p0r = 1'b0;
    tick();
    tick();
    chk("t6_p1_data", dout, 8'hAB);
    tick();
    chk("t6_p1_ack", p1a, 1);
    p1r = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
